// File: rtl/grid_link_router.sv
// Grid link router: one input FIFO per source, one output register per destination,
// round-robin arbitration per destination, unroutable heads dropped and counted.
module grid_link_router #(
    parameter int NUM_LINKS  = 2,
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int FPGA_ID    = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DATA_WIDTH-1:0]           local_in_data,
    input  logic                            local_in_valid,
    output logic                            local_in_ready,
    output logic [DATA_WIDTH-1:0]           local_out_data,
    output logic                            local_out_valid,
    input  logic                            local_out_ready,
    input  logic [NUM_LINKS*DATA_WIDTH-1:0] link_in_data,
    input  logic [NUM_LINKS-1:0]            link_in_valid,
    output logic [NUM_LINKS-1:0]            link_in_ready,
    output logic [NUM_LINKS*DATA_WIDTH-1:0] link_out_data,
    output logic [NUM_LINKS-1:0]            link_out_valid,
    input  logic [NUM_LINKS-1:0]            link_out_ready,
    output logic [15:0]                     drop_count,
    output logic                            router_busy
);
    localparam int NP  = NUM_LINKS + 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;
    localparam int PW  = $clog2(NP);
    localparam int DNW = $clog2(NP + 1);

    logic [DATA_WIDTH-1:0] in_data [NP];
    logic [NP-1:0]         in_valid;
    logic [NP-1:0]         in_ready;
    logic [NP-1:0]         out_ready;
    logic [NP-1:0]         out_valid;
    logic [DATA_WIDTH-1:0] out_data [NP];

    assign in_data[0]      = local_in_data;
    assign in_valid        = {link_in_valid, local_in_valid};
    assign out_ready       = {link_out_ready, local_out_ready};
    assign local_in_ready  = in_ready[0];
    assign link_in_ready   = in_ready[NP-1:1];
    assign local_out_valid = out_valid[0];
    assign link_out_valid  = out_valid[NP-1:1];
    assign local_out_data  = out_data[0];

    generate
        for (genvar k = 0; k < NUM_LINKS; k++) begin : g_link
            assign in_data[k+1] = link_in_data[k*DATA_WIDTH +: DATA_WIDTH];
            assign link_out_data[k*DATA_WIDTH +: DATA_WIDTH] = out_data[k+1];
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [NP][FIFO_DEPTH];
    logic [AW-1:0]         rd_ptr [NP];
    logic [AW-1:0]         wr_ptr [NP];
    logic [CW-1:0]         count [NP];
    logic                  ready_en;
    logic [NP-1:0]         head_valid;
    logic [NP-1:0]         head_drop;
    logic [NP-1:0]         push;
    logic [NP-1:0]         pop;
    logic [DATA_WIDTH-1:0] head_data [NP];
    logic [NP-1:0]         route [NP];
    logic [NP-1:0]         req [NP];
    logic [NP-1:0]         gnt [NP];
    logic [NP-1:0]         found;
    logic [DATA_WIDTH-1:0] load_data [NP];
    logic [PW-1:0]         rr_ptr [NP];
    logic [PW-1:0]         next_ptr [NP];
    logic [DNW-1:0]        drop_num;
    logic [16:0]           drop_sum;

    // One-hot destination for a DST byte; all-zero means unroutable.
    function automatic logic [NP-1:0] route_of(input logic [7:0] dst);
        logic [NP-1:0] oh;
        oh = '0;
        if (dst == 8'(FPGA_ID)) begin
            oh[0] = 1'b1;
        end else begin
            for (int k = 0; k < NUM_LINKS; k++) begin
                if (dst[2:0] == 3'(k)) oh[k+1] = 1'b1;
            end
        end
        return oh;
    endfunction

    always_comb begin
        for (int s = 0; s < NP; s++) begin
            in_ready[s]   = ready_en && (count[s] != CW'(FIFO_DEPTH));
            push[s]       = in_valid[s] && in_ready[s];
            head_valid[s] = (count[s] != '0);
            head_data[s]  = mem[s][rd_ptr[s]];
            route[s]      = route_of(head_data[s][DATA_WIDTH-1 -: 8]);
            head_drop[s]  = head_valid[s] && (route[s] == '0);
        end
    end

    // Two passes give round-robin order starting at rr_ptr without modulo arithmetic.
    always_comb begin
        for (int d = 0; d < NP; d++) begin
            gnt[d]       = '0;
            found[d]     = 1'b0;
            load_data[d] = '0;
            next_ptr[d]  = rr_ptr[d];
            for (int s = 0; s < NP; s++) begin
                req[d][s] = head_valid[s] && route[s][d] && (!out_valid[d] || out_ready[d]);
            end
            for (int s = 0; s < NP; s++) begin
                if (!found[d] && req[d][s] && (s >= int'(rr_ptr[d]))) begin
                    gnt[d][s]    = 1'b1;
                    found[d]     = 1'b1;
                    load_data[d] = head_data[s];
                    next_ptr[d]  = (s == NP - 1) ? '0 : PW'(s + 1);
                end
            end
            for (int s = 0; s < NP; s++) begin
                if (!found[d] && req[d][s] && (s < int'(rr_ptr[d]))) begin
                    gnt[d][s]    = 1'b1;
                    found[d]     = 1'b1;
                    load_data[d] = head_data[s];
                    next_ptr[d]  = (s == NP - 1) ? '0 : PW'(s + 1);
                end
            end
        end
    end

    always_comb begin
        drop_num = '0;
        for (int s = 0; s < NP; s++) begin
            pop[s] = head_drop[s];
            for (int d = 0; d < NP; d++) begin
                pop[s] = pop[s] || gnt[d][s];
            end
            if (head_drop[s]) drop_num = drop_num + DNW'(1);
        end
        drop_sum = {1'b0, drop_count} + 17'(drop_num);
    end

    always_comb begin
        router_busy = |out_valid;
        for (int s = 0; s < NP; s++) begin
            if (head_valid[s]) router_busy = 1'b1;
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NP; s++) begin
            if (push[s]) mem[s][wr_ptr[s]] <= in_data[s];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en   <= 1'b0;
            drop_count <= '0;
            for (int s = 0; s < NP; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            for (int d = 0; d < NP; d++) begin
                out_valid[d] <= 1'b0;
                out_data[d]  <= '0;
                rr_ptr[d]    <= '0;
            end
        end else begin
            ready_en   <= 1'b1;
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            for (int s = 0; s < NP; s++) begin
                if (push[s]) wr_ptr[s] <= wr_ptr[s] + AW'(1);
                if (pop[s])  rd_ptr[s] <= rd_ptr[s] + AW'(1);
                if (push[s] && !pop[s]) begin
                    count[s] <= count[s] + CW'(1);
                end else if (!push[s] && pop[s]) begin
                    count[s] <= count[s] - CW'(1);
                end
            end
            for (int d = 0; d < NP; d++) begin
                if (found[d]) begin
                    out_valid[d] <= 1'b1;
                    out_data[d]  <= load_data[d];
                    rr_ptr[d]    <= next_ptr[d];
                end else if (out_ready[d]) begin
                    out_valid[d] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_grid_link_router.sv
// Randomized and directed bench for grid_link_router; outputs are scored against
// a queue-based model of the routing rules.
`timescale 1ns/1ps
module tb_grid_link_router;
    localparam int NL  = 2;
    localparam int DW  = 64;
    localparam int FD  = 4;
    localparam int FID = 1;
    localparam int NP  = NL + 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [DW-1:0]    local_in_data, local_out_data;
    logic             local_in_valid, local_in_ready, local_out_valid, local_out_ready;
    logic [NL*DW-1:0] link_in_data, link_out_data;
    logic [NL-1:0]    link_in_valid, link_in_ready, link_out_valid, link_out_ready;
    logic [15:0]      drop_count;
    logic             router_busy;

    grid_link_router #(.NUM_LINKS(NL), .DATA_WIDTH(DW), .FIFO_DEPTH(FD), .FPGA_ID(FID)) dut (
        .clk(clk), .reset(reset),
        .local_in_data(local_in_data), .local_in_valid(local_in_valid), .local_in_ready(local_in_ready),
        .local_out_data(local_out_data), .local_out_valid(local_out_valid), .local_out_ready(local_out_ready),
        .link_in_data(link_in_data), .link_in_valid(link_in_valid), .link_in_ready(link_in_ready),
        .link_out_data(link_out_data), .link_out_valid(link_out_valid), .link_out_ready(link_out_ready),
        .drop_count(drop_count), .router_busy(router_busy)
    );

    logic [DW-1:0] drv_data [NP];
    logic [NP-1:0] drv_valid;
    logic [NP-1:0] drv_oready;
    logic [DW-1:0] out_data_a [NP];
    wire  [NP-1:0] in_ready_v  = {link_in_ready, local_in_ready};
    wire  [NP-1:0] out_valid_v = {link_out_valid, local_out_valid};

    assign local_in_data   = drv_data[0];
    assign local_in_valid  = drv_valid[0];
    assign link_in_valid   = drv_valid[NP-1:1];
    assign local_out_ready = drv_oready[0];
    assign link_out_ready  = drv_oready[NP-1:1];
    assign out_data_a[0]   = local_out_data;
    generate
        for (genvar k = 0; k < NL; k++) begin : g_map
            assign link_in_data[k*DW +: DW] = drv_data[k+1];
            assign out_data_a[k+1] = link_out_data[k*DW +: DW];
        end
    endgenerate

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int drop_exp = 0;
    int acc_cnt [NP];
    int rdy_pct [NP];
    logic [DW-1:0] tx_q  [NP][$];
    logic [DW-1:0] exp_q [NP*NP][$];
    logic [DW-1:0] rx_q  [NP][$];
    int            rx_cyc [NP][$];

    // Destination port from the routing rules; -1 when unroutable.
    function automatic int route_of(logic [7:0] dst);
        int l;
        l = int'(dst) % 8;
        if (int'(dst) == FID) return 0;
        if (l < NL) return l + 1;
        return -1;
    endfunction

    function automatic logic [DW-1:0] mk_msg(logic [7:0] dst, int src, int seq);
        logic [31:0] r;
        r = $urandom();
        return {dst, 8'(src), 16'(seq), r};
    endfunction

    function automatic logic [7:0] unroutable_dst();
        return 8'(8 * $urandom_range(0, 31) + $urandom_range(2, 7));
    endfunction

    task automatic model_accept(input int s, input logic [DW-1:0] m);
        int r;
        r = route_of(m[DW-1 -: 8]);
        if (r < 0) begin
            if (drop_exp < 65535) drop_exp++;
        end else begin
            exp_q[s*NP + r].push_back(m);
        end
    endtask

    task automatic clear_model();
        for (int s = 0; s < NP; s++) begin
            tx_q[s].delete(); rx_q[s].delete(); rx_cyc[s].delete();
            acc_cnt[s] = 0; rdy_pct[s] = 100;
        end
        for (int i = 0; i < NP*NP; i++) exp_q[i].delete();
        drop_exp = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drv_valid = '0;
        drv_oready = '1;
        for (int s = 0; s < NP; s++) drv_data[s] = '0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one cycle at the falling edge; record the handshakes the next rising edge completes.
    task automatic step();
        @(negedge clk);
        for (int s = 0; s < NP; s++) begin
            if (tx_q[s].size() > 0) begin
                drv_valid[s] = 1'b1; drv_data[s] = tx_q[s][0];
            end else begin
                drv_valid[s] = 1'b0; drv_data[s] = '0;
            end
        end
        for (int d = 0; d < NP; d++)
            drv_oready[d] = (rdy_pct[d] >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < rdy_pct[d]);
        #1;
        for (int s = 0; s < NP; s++) begin
            if (drv_valid[s] && in_ready_v[s]) begin
                model_accept(s, tx_q[s].pop_front());
                acc_cnt[s]++;
            end
        end
        for (int d = 0; d < NP; d++) begin
            if (out_valid_v[d] && drv_oready[d]) begin
                rx_q[d].push_back(out_data_a[d]);
                rx_cyc[d].push_back(cyc);
            end
        end
        cyc++;
    endtask

    task automatic run_idle(input int max_cyc, output bit ok);
        bit pending;
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            step();
            pending = 1'b0;
            for (int s = 0; s < NP; s++) if (tx_q[s].size() > 0) pending = 1'b1;
            if (!pending && drv_valid == '0 && !router_busy) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        drv_valid = '1;
        #1;
        n_checks++; if (in_ready_v !== 3'b000) begin n_fail++; $display("FAIL reset_ready: got %b want 000", in_ready_v); end
        n_checks++; if (out_valid_v !== 3'b000) begin n_fail++; $display("FAIL reset_valid: got %b want 000", out_valid_v); end
        n_checks++; if ({out_data_a[2], out_data_a[1], out_data_a[0]} !== '0) begin n_fail++; $display("FAIL reset_data: got nonzero output data"); end
        n_checks++; if (drop_count !== 16'h0) begin n_fail++; $display("FAIL reset_drop: got %0h want 0", drop_count); end
        n_checks++; if (router_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", router_busy); end
        @(negedge clk);
        drv_valid = '0;
        reset = 1'b0;
        #1;
        n_checks++; if (in_ready_v !== 3'b000) begin n_fail++; $display("FAIL ready_before_edge: got %b want 000", in_ready_v); end
        @(posedge clk); #1;
        n_checks++; if (in_ready_v !== 3'b111) begin n_fail++; $display("FAIL ready_after_edge: got %b want 111", in_ready_v); end
    endtask

    task automatic test_single_route();
        logic [DW-1:0] m;
        do_reset();
        m = mk_msg(8'd8, 0, 0);
        @(negedge clk);
        drv_data[0] = m; drv_valid[0] = 1'b1; #1;
        n_checks++; if (local_in_ready !== 1'b1) begin n_fail++; $display("FAIL single_accept: got %b want 1", local_in_ready); end
        @(negedge clk);
        drv_valid[0] = 1'b0; #1;
        n_checks++; if (link_out_valid[0] !== 1'b0) begin n_fail++; $display("FAIL single_lat1: got %b want 0", link_out_valid[0]); end
        @(negedge clk); #1;
        n_checks++; if (out_valid_v !== 3'b010) begin n_fail++; $display("FAIL single_lat2: got %b want 010", out_valid_v); end
        n_checks++; if (link_out_data[DW-1:0] !== m) begin n_fail++; $display("FAIL single_data: got %h want %h", link_out_data[DW-1:0], m); end
        @(negedge clk); #1;
        n_checks++; if (out_valid_v !== 3'b000) begin n_fail++; $display("FAIL single_once: got %b want 000", out_valid_v); end
    endtask

    task automatic test_contention();
        logic [DW-1:0] msgs [NP][4];
        bit ok;
        do_reset();
        for (int q = 0; q < 4; q++)
            for (int s = 0; s < NP; s++) begin
                msgs[s][q] = mk_msg(8'(FID), s, q);
                tx_q[s].push_back(msgs[s][q]);
            end
        run_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL contention_timeout: router not idle after 100 cycles"); end
        n_checks++; if (rx_q[0].size() != 12) begin n_fail++; $display("FAIL contention_count: got %0d want 12", rx_q[0].size()); end
        for (int i = 0; i < 12 && i < rx_q[0].size(); i++) begin
            n_checks++;
            if (rx_q[0][i] !== msgs[i % 3][i / 3]) begin
                n_fail++; $display("FAIL contention_order[%0d]: got %h want %h", i, rx_q[0][i], msgs[i % 3][i / 3]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] msgs [6];
        bit ok;
        do_reset();
        rdy_pct[0] = 0;
        for (int i = 0; i < 6; i++) begin
            msgs[i] = mk_msg(8'(FID), 1, i);
            tx_q[1].push_back(msgs[i]);
        end
        repeat (12) step();
        n_checks++; if (acc_cnt[1] != 5) begin n_fail++; $display("FAIL bp_accepts: got %0d want 5", acc_cnt[1]); end
        n_checks++; if (in_ready_v[1] !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", in_ready_v[1]); end
        n_checks++; if (local_out_valid !== 1'b1 || local_out_data !== msgs[0]) begin
            n_fail++; $display("FAIL bp_hold: got valid %b data %h want 1 %h", local_out_valid, local_out_data, msgs[0]);
        end
        rdy_pct[0] = 100;
        run_idle(100, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: router not idle after release"); end
        n_checks++; if (rx_q[0].size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", rx_q[0].size()); end
        for (int i = 0; i < 6 && i < rx_q[0].size(); i++) begin
            n_checks++;
            if (rx_q[0][i] !== msgs[i]) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, rx_q[0][i], msgs[i]); end
        end
    endtask

    task automatic test_unroutable();
        bit ok;
        int total;
        do_reset();
        for (int s = 0; s < NP; s++) tx_q[s].push_back(mk_msg(8'd7, s, 0));
        run_idle(50, ok);
        total = rx_q[0].size() + rx_q[1].size() + rx_q[2].size();
        n_checks++; if (!ok || total != 0) begin n_fail++; $display("FAIL drop_no_output: got %0d outputs idle=%b want 0 idle=1", total, ok); end
        n_checks++; if (drop_count !== 16'(drop_exp)) begin n_fail++; $display("FAIL drop_three: got %0d want %0d", drop_count, drop_exp); end
        for (int c = 0; c < 20000; c++) begin
            for (int s = 0; s < NP; s++) if (tx_q[s].size() < 2) tx_q[s].push_back(mk_msg(unroutable_dst(), s, c));
            step();
        end
        run_idle(50, ok);
        n_checks++; if (drop_count !== 16'(drop_exp)) begin n_fail++; $display("FAIL drop_bulk: got %0d want %0d", drop_count, drop_exp); end
        for (int c = 0; c < 2000; c++) begin
            for (int s = 0; s < NP; s++) if (tx_q[s].size() < 2) tx_q[s].push_back(mk_msg(unroutable_dst(), s, c));
            step();
        end
        run_idle(50, ok);
        n_checks++; if (drop_count !== 16'(drop_exp)) begin n_fail++; $display("FAIL drop_saturate: got %0h want %0h", drop_count, drop_exp); end
        for (int s = 0; s < NP; s++) tx_q[s].push_back(mk_msg(8'd7, s, 1));
        run_idle(50, ok);
        n_checks++; if (drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL drop_hold: got %0h want ffff", drop_count); end
    endtask

    task automatic test_mid_reset();
        int total;
        do_reset();
        for (int s = 0; s < NP; s++) rdy_pct[s] = 0;
        tx_q[0].push_back(mk_msg(8'd8, 0, 0));
        tx_q[1].push_back(mk_msg(8'd9, 1, 0));
        tx_q[2].push_back(mk_msg(8'(FID), 2, 0));
        repeat (4) step();
        n_checks++; if (router_busy !== 1'b1 || out_valid_v !== 3'b111) begin
            n_fail++; $display("FAIL midrst_pre: got busy %b valid %b want 1 111", router_busy, out_valid_v);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (out_valid_v !== 3'b000) begin n_fail++; $display("FAIL midrst_valid: got %b want 000", out_valid_v); end
        n_checks++; if (router_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", router_busy); end
        @(negedge clk);
        clear_model();
        drv_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (10) step();
        total = rx_q[0].size() + rx_q[1].size() + rx_q[2].size();
        n_checks++; if (total != 0 || router_busy !== 1'b0) begin
            n_fail++; $display("FAIL midrst_stale: got %0d outputs busy %b want 0 0", total, router_busy);
        end
    endtask

    task automatic test_hairpin();
        logic [DW-1:0] routed [$];
        logic [DW-1:0] m;
        bit ok;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            m = mk_msg((i % 2 == 0) ? 8'd4 : 8'd9, 2, i);
            tx_q[2].push_back(m);
            if (i % 2 == 1) routed.push_back(m);
        end
        run_idle(100, ok);
        n_checks++; if (!ok || rx_q[2].size() != 8) begin n_fail++; $display("FAIL hairpin_count: got %0d idle=%b want 8 idle=1", rx_q[2].size(), ok); end
        n_checks++; if (rx_q[0].size() + rx_q[1].size() != 0) begin n_fail++; $display("FAIL hairpin_leak: got %0d stray outputs want 0", rx_q[0].size() + rx_q[1].size()); end
        n_checks++; if (drop_count !== 16'(drop_exp)) begin n_fail++; $display("FAIL hairpin_drops: got %0d want %0d", drop_count, drop_exp); end
        for (int i = 0; i < 8 && i < rx_q[2].size(); i++) begin
            n_checks++;
            if (rx_q[2][i] !== routed[i]) begin n_fail++; $display("FAIL hairpin_data[%0d]: got %h want %h", i, rx_q[2][i], routed[i]); end
            if (i > 0) begin
                n_checks++;
                if (rx_cyc[2][i] - rx_cyc[2][i-1] != 2) begin
                    n_fail++; $display("FAIL hairpin_gap[%0d]: got %0d want 2", i, rx_cyc[2][i] - rx_cyc[2][i-1]);
                end
            end
        end
    endtask

    task automatic test_throughput();
        logic [DW-1:0] msgs [12];
        bit ok;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            msgs[i] = mk_msg(8'(8 * $urandom_range(1, 31) + 1), 2, i);
            tx_q[2].push_back(msgs[i]);
        end
        run_idle(100, ok);
        n_checks++; if (!ok || rx_q[2].size() != 12) begin n_fail++; $display("FAIL tput_count: got %0d idle=%b want 12 idle=1", rx_q[2].size(), ok); end
        for (int i = 0; i < 12 && i < rx_q[2].size(); i++) begin
            n_checks++;
            if (rx_q[2][i] !== msgs[i]) begin n_fail++; $display("FAIL tput_data[%0d]: got %h want %h", i, rx_q[2][i], msgs[i]); end
            if (i > 0) begin
                n_checks++;
                if (rx_cyc[2][i] - rx_cyc[2][i-1] != 1) begin
                    n_fail++; $display("FAIL tput_gap[%0d]: got %0d want 1", i, rx_cyc[2][i] - rx_cyc[2][i-1]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] m;
        logic [DW-1:0] e;
        logic [7:0] dst;
        int s;
        int left;
        bit ok;
        do_reset();
        for (int d = 0; d < NP; d++) rdy_pct[d] = int'($urandom_range(40, 100));
        for (int src = 0; src < NP; src++) begin
            for (int i = 0; i < 30; i++) begin
                case ($urandom_range(0, 4))
                    0: dst = 8'(FID);
                    1: dst = 8'(8 * $urandom_range(0, 31));
                    2: dst = 8'(8 * $urandom_range(1, 31) + 1);
                    3: dst = unroutable_dst();
                    default: dst = 8'($urandom_range(0, 255));
                endcase
                tx_q[src].push_back(mk_msg(dst, src, i));
            end
        end
        run_idle(3000, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL random_timeout: router not idle after 3000 cycles"); end
        for (int d = 0; d < NP; d++) begin
            while (rx_q[d].size() > 0) begin
                m = rx_q[d].pop_front();
                s = int'(m[DW-9 -: 8]);
                n_checks++;
                if (s >= NP || exp_q[s*NP + d].size() == 0) begin
                    n_fail++; $display("FAIL random_unexpected: port %0d got %h want nothing", d, m);
                end else begin
                    e = exp_q[s*NP + d].pop_front();
                    if (m !== e) begin n_fail++; $display("FAIL random_data: port %0d got %h want %h", d, m, e); end
                end
            end
        end
        left = 0;
        for (int i = 0; i < NP*NP; i++) left += exp_q[i].size();
        n_checks++; if (left != 0) begin n_fail++; $display("FAIL random_missing: got %0d undelivered want 0", left); end
        n_checks++; if (drop_count !== 16'(drop_exp)) begin n_fail++; $display("FAIL random_drops: got %0d want %0d", drop_count, drop_exp); end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        drv_valid = '0;
        drv_oready = '1;
        for (int s = 0; s < NP; s++) drv_data[s] = '0;
        clear_model();
        test_reset();
        test_single_route();
        test_contention();
        test_backpressure();
        test_unroutable();
        test_mid_reset();
        test_hairpin();
        test_throughput();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
